bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset SHALL be synchronous and active-high, sampled only on the rising edge of clk.
REQ-002 Parameter width, default 16: packet width in bits.
REQ-003 Parameter drvrs, default 4: number of attached FIFOs/devices (2..16).
REQ-004 Parameter broadcast, default 8'hFF: destination ID meaning "all devices".
REQ-005 clk  input  1: rising-edge clock.
REQ-006 reset  input  1: synchronous active-high reset.
REQ-007 pndng_i  input  drvrs: bit n high = FIFO n is non-empty.
REQ-008 dato_i  input  drvrs*width: slice n = head word (dato_o) of FIFO n.
REQ-009 pop_o  output  drvrs: one-hot pop_i pulse to the granted FIFO.
REQ-010 push_o  output  drvrs: push_i pulses to destination FIFO(s).
REQ-011 dato_o  output  width: bus word, shared dato_i of all destination FIFOs.
REQ-012 grant_o  output  drvrs: one-hot, current bus owner; 0 when idle.
REQ-013 busy_o  output  1: high while a transfer is in progress.
REQ-014 err_o  output  1: one-cycle pulse on a dropped packet.

Function
REQ-015 Packet format SHALL be: dato[width-1:width-8] = destination ID; remaining bits = payload, never modified.
REQ-016 All outputs SHALL be registered.
REQ-017 FSM states: IDLE, POP, PUSH; reset state IDLE.
REQ-018 IDLE: if pndng_i != 0, select the first set bit scanning from rr pointer upward, wrapping drvrs-1 -> 0; at the edge: dato_o <= slice sel, pop_o <= onehot(sel), grant_o <= onehot(sel), busy_o <= 1, go to POP. If pndng_i == 0, stay in IDLE with all outputs held at reset values except dato_o (which holds its value).
REQ-019 POP: pop_o <= 0; decode ID of the latched dato_o and go to PUSH:
  - ID == broadcast: push_o <= all ones except bit sel.
  - ID < drvrs and ID != sel: push_o <= onehot(ID).
  - otherwise (ID >= drvrs and not broadcast, or ID == sel): push_o <= 0, err_o <= 1.
REQ-020 PUSH: push_o <= 0, err_o <= 0, grant_o <= 0, busy_o <= 0, rr pointer <= (sel+1) mod drvrs, go to IDLE.
REQ-021 Latency: pndng_i seen at edge N -> pop_o high in cycle N..N+1 -> push_o high in cycle N+1..N+2. Each pulse SHALL last exactly one cycle. Throughput SHALL be one packet per 3 cycles.
REQ-022 pop_o SHALL pulse exactly once per granted packet, including dropped packets.
REQ-023 Changes on pndng_i or dato_i during POP/PUSH SHALL be ignored; dato_o SHALL remain stable from POP through PUSH.
REQ-024 Rotating priority SHALL prevent starvation: with all drvrs pending continuously, each device SHALL be granted once per drvrs transfers.
REQ-025 Full destination FIFOs are not detected; a push into a full FIFO is the FIFO's responsibility.

Reset
REQ-026 When reset is high at an edge: state <= IDLE; rr pointer <= 0; pop_o, push_o, grant_o, dato_o, busy_o, err_o <= 0.
REQ-027 Reset SHALL override every state. A packet popped before reset but not yet pushed SHALL be lost, with no push_o pulse emitted.
REQ-028 In the first cycle after reset deasserts, the block SHALL be in IDLE and arbitration SHALL start at device 0.

Verification
REQ-029 Unicast: pndng_i=4'b0001, dato_i[0]=16'h02A5 -> pop_o=0001 one cycle later, then push_o=0100 with dato_o=16'h02A5 for one cycle; err_o stays 0.
REQ-030 Broadcast: pndng_i=4'b0100, dato_i[2]=16'hFF3C -> pop_o=0100, then push_o=1011 with dato_o=16'hFF3C.
REQ-031 Round-robin: pndng_i=4'b1111 held, all IDs valid -> grant order 0,1,2,3,0; a transfer every 3 cycles.
REQ-032 Drop: dato_i[1]=16'h0711 (ID 7 >= drvrs) then dato_i[3]=16'h0311 (self) -> each gives a pop_o pulse, push_o=0000, err_o=1 for one cycle.
REQ-033 Reset mid-transfer: assert reset in the POP cycle -> push_o never pulses, all outputs 0; next pending request is granted starting from device 0.
REQ-034 Back-to-back with 8-deep, 16-bit FIFOs on all ports: 8 packets from device 0 to device 1 -> FIFO 1 holds all 8 words in order and FIFO 0 ends empty.

Source files
------------

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin FIFO-to-FIFO packet bus with unicast/broadcast routing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int         width     = 16,
    parameter int         drvrs     = 4,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [drvrs-1:0]       pndng_i,
    input  logic [drvrs*width-1:0] dato_i,
    output logic [drvrs-1:0]       pop_o,
    output logic [drvrs-1:0]       push_o,
    output logic [width-1:0]       dato_o,
    output logic [drvrs-1:0]       grant_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int c_SEL_W = $clog2(drvrs);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_PUSH = 2'd2
    } state_t;

    state_t             r_state, w_state_nx;
    logic [c_SEL_W-1:0] r_rr, w_rr_nx;
    logic [c_SEL_W-1:0] r_sel, w_sel_nx;
    logic [width-1:0]   r_dato, w_dato_nx;
    logic [drvrs-1:0]   r_pop, w_pop_nx;
    logic [drvrs-1:0]   r_push, w_push_nx;
    logic [drvrs-1:0]   r_grant, w_grant_nx;
    logic               r_busy, w_busy_nx;
    logic               r_err, w_err_nx;

    logic               w_found;
    logic [c_SEL_W-1:0] w_pick;
    logic [c_SEL_W-1:0] w_idx_s;
    int                 w_idx;
    logic [drvrs-1:0]   w_onehot_pick;
    logic [drvrs-1:0]   w_onehot_sel;
    logic [drvrs-1:0]   w_onehot_id;
    logic [7:0]         w_id;

    // First pending device at or above the rotating pointer, wrapping to 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        w_idx_s = '0;
        for (int i = 0; i < drvrs; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= drvrs) begin
                w_idx = w_idx - drvrs;
            end
            w_idx_s = w_idx[c_SEL_W-1:0];
            if (!w_found && pndng_i[w_idx_s]) begin
                w_found = 1'b1;
                w_pick  = w_idx_s;
            end
        end
    end

    always_comb begin
        w_id          = r_dato[width-1 -: 8];
        w_onehot_pick = '0;
        w_onehot_pick[w_pick] = 1'b1;
        w_onehot_sel  = '0;
        w_onehot_sel[r_sel] = 1'b1;
        w_onehot_id   = '0;
        w_onehot_id[w_id[c_SEL_W-1:0]] = 1'b1;
    end

    always_comb begin
        w_state_nx = r_state;
        w_rr_nx    = r_rr;
        w_sel_nx   = r_sel;
        w_dato_nx  = r_dato;
        w_pop_nx   = r_pop;
        w_push_nx  = r_push;
        w_grant_nx = r_grant;
        w_busy_nx  = r_busy;
        w_err_nx   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_nx   = w_pick;
                    w_dato_nx  = dato_i[w_pick*width +: width];
                    w_pop_nx   = w_onehot_pick;
                    w_grant_nx = w_onehot_pick;
                    w_busy_nx  = 1'b1;
                    w_state_nx = S_POP;
                end else begin
                    w_pop_nx   = '0;
                    w_push_nx  = '0;
                    w_grant_nx = '0;
                    w_busy_nx  = 1'b0;
                    w_err_nx   = 1'b0;
                end
            end
            S_POP: begin
                w_pop_nx   = '0;
                w_state_nx = S_PUSH;
                if (w_id == broadcast) begin
                    w_push_nx = ~w_onehot_sel;
                end else if ((int'(w_id) < drvrs) && (int'(w_id) != int'(r_sel))) begin
                    w_push_nx = w_onehot_id;
                end else begin
                    // Unknown destination or loop-back to the sender: drop it.
                    w_push_nx = '0;
                    w_err_nx  = 1'b1;
                end
            end
            S_PUSH: begin
                w_push_nx  = '0;
                w_err_nx   = 1'b0;
                w_grant_nx = '0;
                w_busy_nx  = 1'b0;
                w_rr_nx    = (int'(r_sel) == drvrs - 1) ? '0 : r_sel + c_SEL_W'(1);
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_sel   <= '0;
            r_dato  <= '0;
            r_pop   <= '0;
            r_push  <= '0;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rr    <= w_rr_nx;
            r_sel   <= w_sel_nx;
            r_dato  <= w_dato_nx;
            r_pop   <= w_pop_nx;
            r_push  <= w_push_nx;
            r_grant <= w_grant_nx;
            r_busy  <= w_busy_nx;
            r_err   <= w_err_nx;
        end
    end

    assign pop_o   = r_pop;
    assign push_o  = r_push;
    assign dato_o  = r_dato;
    assign grant_o = r_grant;
    assign busy_o  = r_busy;
    assign err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter (4 devices, 16 bit).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] dato_in;
    logic [N-1:0]   pop, push, grant;
    logic [W-1:0]   dato;
    logic           busy, err;

    logic [N-1:0]   drv_pndng = '0;
    logic [N*W-1:0] drv_dato = '0;
    logic           fifo_mode = 1'b0;
    logic           src_load = 1'b0;
    logic           dst_clr = 1'b0;

    logic [W-1:0]   src_mem [8];
    logic [3:0]     src_cnt = '0;
    logic [2:0]     src_rd = '0;
    logic [W-1:0]   dst_mem [N][8];
    int             dst_cnt [N];

    int n_vec = 0;
    int n_err = 0;

    logic [13:0] ctl;
    assign ctl = {pop, push, grant, busy, err};

    assign pndng   = fifo_mode ? {3'b000, (src_cnt != 4'd0)} : drv_pndng;
    assign dato_in = fifo_mode ? {48'h0, src_mem[src_rd]} : drv_dato;

    always #5 clk = ~clk;

    bus_arbiter #(.width(W), .drvrs(N), .broadcast(8'hFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng_i (pndng),
        .dato_i  (dato_in),
        .pop_o   (pop),
        .push_o  (push),
        .dato_o  (dato),
        .grant_o (grant),
        .busy_o  (busy),
        .err_o   (err)
    );

    // Source FIFO on device 0 and destination FIFOs on every device.
    always @(posedge clk) begin
        if (src_load) begin
            src_cnt <= 4'd8;
            src_rd  <= '0;
        end else if (fifo_mode && pop[0] && src_cnt != 4'd0) begin
            src_cnt <= src_cnt - 4'd1;
            src_rd  <= src_rd + 3'd1;
        end
        for (int n = 0; n < N; n++) begin
            if (dst_clr) begin
                dst_cnt[n] <= 0;
            end else if (fifo_mode && push[n] && dst_cnt[n] < 8) begin
                dst_mem[n][dst_cnt[n][2:0]] <= dato;
                dst_cnt[n] <= dst_cnt[n] + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drv_pndng = 4'hF;
        drv_dato  = {4{16'h0155}};
        step();
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 14'd0); end
        n_vec++;
        if (dato !== 16'h0) begin n_err++; $display("FAIL reset_dato: got %h want 0000", dato); end
        reset = 1'b0;
        drv_pndng = '0;
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL idle_after_reset: got %b want %b", ctl, 14'd0); end
    endtask

    task automatic test_unicast();
        drv_dato[15:0] = 16'h02A5;
        drv_pndng = 4'b0001;
        step();
        n_vec++;
        if (ctl !== {4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0}) begin n_err++; $display("FAIL uni_pop: got %b want 00010000000110", ctl); end
        n_vec++;
        if (dato !== 16'h02A5) begin n_err++; $display("FAIL uni_dato_pop: got %h want 02a5", dato); end
        drv_pndng = '0;
        drv_dato  = '0;
        step();
        n_vec++;
        if (ctl !== {4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0}) begin n_err++; $display("FAIL uni_push: got %b want 00000100000110", ctl); end
        n_vec++;
        if (dato !== 16'h02A5) begin n_err++; $display("FAIL uni_dato_push: got %h want 02a5", dato); end
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL uni_end: got %b want 0", ctl); end
        n_vec++;
        if (dato !== 16'h02A5) begin n_err++; $display("FAIL uni_dato_hold: got %h want 02a5", dato); end
    endtask

    task automatic test_broadcast();
        drv_dato[47:32] = 16'hFF3C;
        drv_pndng = 4'b0100;
        step();
        n_vec++;
        if (ctl !== {4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0}) begin n_err++; $display("FAIL bc_pop: got %b want 01000000010010", ctl); end
        drv_pndng = '0;
        step();
        n_vec++;
        if (ctl !== {4'b0000, 4'b1011, 4'b0100, 1'b1, 1'b0}) begin n_err++; $display("FAIL bc_push: got %b want 00001011010010", ctl); end
        n_vec++;
        if (dato !== 16'hFF3C) begin n_err++; $display("FAIL bc_dato: got %h want ff3c", dato); end
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL bc_end: got %b want 0", ctl); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_p;
        reset_pulse();
        drv_dato  = {16'h00A3, 16'h03A2, 16'h02A1, 16'h01A0};
        drv_pndng = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            exp_p = 4'b0001 << ((k + 1) % 4);
            step();
            n_vec++;
            if ({pop, grant} !== {exp_g, exp_g}) begin n_err++; $display("FAIL rr_grant%0d: got pop %b grant %b want %b", k, pop, grant, exp_g); end
            step();
            n_vec++;
            if ({push, err} !== {exp_p, 1'b0}) begin n_err++; $display("FAIL rr_push%0d: got push %b err %b want %b err 0", k, push, err, exp_p); end
            step();
            n_vec++;
            if (ctl !== 14'd0) begin n_err++; $display("FAIL rr_idle%0d: got %b want 0", k, ctl); end
        end
        drv_pndng = '0;
    endtask

    task automatic test_drop();
        reset_pulse();
        drv_dato[31:16] = 16'h0711;
        drv_pndng = 4'b0010;
        step();
        n_vec++;
        if (ctl !== {4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin n_err++; $display("FAIL drop7_pop: got %b want 00100000001010", ctl); end
        drv_pndng = '0;
        step();
        n_vec++;
        if (ctl !== {4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1}) begin n_err++; $display("FAIL drop7_err: got %b want 00000000001011", ctl); end
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL drop7_end: got %b want 0", ctl); end
        drv_dato[63:48] = 16'h0311;
        drv_pndng = 4'b1000;
        step();
        n_vec++;
        if (ctl !== {4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0}) begin n_err++; $display("FAIL dropself_pop: got %b want 10000000100010", ctl); end
        drv_pndng = '0;
        step();
        n_vec++;
        if (ctl !== {4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b1}) begin n_err++; $display("FAIL dropself_err: got %b want 00000000100011", ctl); end
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL dropself_end: got %b want 0", ctl); end
    endtask

    task automatic test_reset_mid();
        reset_pulse();
        drv_dato[31:16] = 16'h0011;
        drv_pndng = 4'b0010;
        step();
        drv_pndng = '0;
        step();
        n_vec++;
        if (push !== 4'b0001) begin n_err++; $display("FAIL mid_pre_push: got %b want 0001", push); end
        step();
        drv_dato[47:32] = 16'h0001;
        drv_dato[15:0]  = 16'h0102;
        drv_pndng = 4'b0101;
        step();
        n_vec++;
        if (pop !== 4'b0100) begin n_err++; $display("FAIL mid_pop: got %b want 0100", pop); end
        reset = 1'b1;
        step();
        n_vec++;
        if (ctl !== 14'd0) begin n_err++; $display("FAIL mid_reset_ctl: got %b want 0", ctl); end
        n_vec++;
        if (dato !== 16'h0) begin n_err++; $display("FAIL mid_reset_dato: got %h want 0000", dato); end
        reset = 1'b0;
        step();
        n_vec++;
        if (ctl !== {4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0}) begin n_err++; $display("FAIL mid_regrant: got %b want 00010000000110", ctl); end
        drv_pndng = '0;
        step();
        n_vec++;
        if ({push, dato} !== {4'b0010, 16'h0102}) begin n_err++; $display("FAIL mid_push: got %b %h want 0010 0102", push, dato); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        reset_pulse();
        for (int k = 0; k < 8; k++) begin
            src_mem[k] = 16'h0100 + 16'(k * 19);
        end
        src_load = 1'b1;
        dst_clr  = 1'b1;
        step();
        src_load = 1'b0;
        dst_clr  = 1'b0;
        fifo_mode = 1'b1;
        cyc = 0;
        while (cyc < 80 && !(dst_cnt[1] == 8 && busy == 1'b0)) begin
            step();
            cyc++;
        end
        n_vec++;
        if (cyc >= 80) begin n_err++; $display("FAIL b2b_timeout: got %0d cycles want < 80", cyc); end
        n_vec++;
        if (dst_cnt[1] !== 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", dst_cnt[1]); end
        for (int k = 0; k < 8; k++) begin
            n_vec++;
            if (dst_mem[1][k] !== 16'h0100 + 16'(k * 19)) begin
                n_err++;
                $display("FAIL b2b_word%0d: got %h want %h", k, dst_mem[1][k], 16'h0100 + 16'(k * 19));
            end
        end
        n_vec++;
        if (src_cnt !== 4'd0) begin n_err++; $display("FAIL b2b_src_empty: got %0d want 0", src_cnt); end
        n_vec++;
        if ({dst_cnt[0], dst_cnt[2], dst_cnt[3]} !== 96'd0) begin
            n_err++;
            $display("FAIL b2b_other_dst: got %0d %0d %0d want 0 0 0", dst_cnt[0], dst_cnt[2], dst_cnt[3]);
        end
        fifo_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_broadcast();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
